cpu_divider: RTL and testbench

- Iterative restoring radix-2 divider that produces p4_quotient, p4_remainder and p4_divider_done for the completion stage.
- Started by the execute stage in the same cycle a DIVU/DIVS/MODU/MODS op advances into p4. While the op sits in p4 and done is low, completion holds the pipeline stalled.
- One divider instance serves both quotient and remainder ops.

---
 rtl/cpu_divider.sv | 141 ++++++++++++++
 tb/tb_cpu_divider.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_divider.sv
// cpu_divider: iterative restoring radix-2 divider for DIVU/DIVS/MODU/MODS.
// One quotient bit per cycle, then a single sign-fixup cycle. Divide-by-zero
// and signed overflow bypass the iteration and complete one cycle after start.
module cpu_divider #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p3_start,
    input  logic             p3_signed,
    input  logic [WIDTH-1:0] p3_dividend,
    input  logic [WIDTH-1:0] p3_divisor,
    output logic [WIDTH-1:0] p4_quotient,
    output logic [WIDTH-1:0] p4_remainder,
    output logic             p4_divider_done,
    output logic             p4_divider_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [CNT_BITS-1:0] counter;
    logic [WIDTH-1:0]    rem, quo, div_mag;
    logic                neg_quo, neg_rem;

    // Operand magnitudes and special-case detection at the start edge
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             div_zero, sgn_ovf, special;

    // BUSY datapath: shift in next dividend bit and trial-subtract
    logic [WIDTH:0]   rem_shifted, trial;

    // Start-time operand preparation
    always_comb begin
        dvd_neg  = p3_signed & p3_dividend[WIDTH-1];
        dvs_neg  = p3_signed & p3_divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? (~p3_dividend + 1'b1) : p3_dividend;
        dvs_mag  = dvs_neg ? (~p3_divisor + 1'b1) : p3_divisor;
        div_zero = (p3_divisor == '0);
        sgn_ovf  = p3_signed && (p3_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                             && (p3_divisor == '1);
        special  = div_zero | sgn_ovf;
    end

    // One restoring-division step
    always_comb begin
        rem_shifted = {rem, quo[WIDTH-1]};
        trial       = rem_shifted - {1'b0, div_mag};
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start overrides any state. Special cases route through
    // FIXUP with preloaded results so done rises exactly one edge after start.
    always_comb begin
        state_next = state;
        if (p3_start) begin
            state_next = special ? FIXUP : BUSY;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                BUSY:    if (counter == CNT_BITS'(WIDTH - 1)) state_next = FIXUP;
                FIXUP:   state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        p4_divider_done = (state == IDLE) || (state == DONE);
        p4_divider_busy = (state == BUSY) || (state == FIXUP);
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter      <= '0;
            rem          <= '0;
            quo          <= '0;
            div_mag      <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            p4_quotient  <= '0;
            p4_remainder <= '0;
        end else if (p3_start) begin
            counter <= '0;
            div_mag <= dvs_mag;
            if (div_zero) begin
                quo     <= '1;
                rem     <= p3_dividend;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end else if (sgn_ovf) begin
                quo     <= {1'b1, {(WIDTH-1){1'b0}}};
                rem     <= '0;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end else begin
                quo     <= dvd_mag;
                rem     <= '0;
                neg_quo <= dvd_neg ^ dvs_neg;
                neg_rem <= dvd_neg;
            end
        end else begin
            case (state)
                BUSY: begin
                    counter <= counter + CNT_BITS'(1);
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIXUP: begin
                    p4_quotient  <= neg_quo ? (~quo + 1'b1) : quo;
                    p4_remainder <= neg_rem ? (~rem + 1'b1) : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_divider.sv
// Directed self-checking bench for cpu_divider (WIDTH=32).
module tb_cpu_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        p3_start;
    logic        p3_signed;
    logic [31:0] p3_dividend;
    logic [31:0] p3_divisor;
    logic [31:0] p4_quotient;
    logic [31:0] p4_remainder;
    logic        p4_divider_done;
    logic        p4_divider_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cycles;

    cpu_divider #(.WIDTH(32), .CNT_BITS(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .p3_start        (p3_start),
        .p3_signed       (p3_signed),
        .p3_dividend     (p3_dividend),
        .p3_divisor      (p3_divisor),
        .p4_quotient     (p4_quotient),
        .p4_remainder    (p4_remainder),
        .p4_divider_done (p4_divider_done),
        .p4_divider_busy (p4_divider_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns #1 after that edge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        p3_start    = 1'b1;
        p3_signed   = sgn;
        p3_dividend = a;
        p3_divisor  = b;
        @(posedge clock);
        #1;
        p3_start    = 1'b0;
        p3_dividend = 32'hDEAD_BEEF;
        p3_divisor  = 32'h0BAD_F00D;
    endtask

    // Count edges until done is seen high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (p4_divider_done) break;
        end
    endtask

    task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] q, input logic [31:0] r);
        int n;
        start_op(sgn, a, b);
        check({tag, "_done_low"}, {31'd0, p4_divider_done}, 32'd0);
        wait_done(n);
        check({tag, "_latency"}, n, lat);
        check({tag, "_quo"}, p4_quotient, q);
        check({tag, "_rem"}, p4_remainder, r);
    endtask

    initial begin
        reset       = 1'b0;
        p3_start    = 1'b0;
        p3_signed   = 1'b0;
        p3_dividend = '0;
        p3_divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", {31'd0, p4_divider_done}, 32'd1);
        check("rst_busy", {31'd0, p4_divider_busy}, 32'd0);
        check("rst_quo", p4_quotient, 32'd0);
        check("rst_rem", p4_remainder, 32'd0);
        reset = 1'b1;

        // 100/7 unsigned, with busy observed and result held
        start_op(1'b0, 32'd100, 32'd7);
        check("u100_busy", {31'd0, p4_divider_busy}, 32'd1);
        wait_done(cycles);
        check("u100_latency", cycles, 33);
        check("u100_quo", p4_quotient, 32'd14);
        check("u100_rem", p4_remainder, 32'd2);
        repeat (5) @(posedge clock);
        #1;
        check("u100_hold_done", {31'd0, p4_divider_done}, 32'd1);
        check("u100_hold_quo", p4_quotient, 32'd14);
        check("u100_hold_rem", p4_remainder, 32'd2);

        run("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2);
        run("u_div0", 1'b0, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        run("s_div0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0);
        run("u_8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
        run("u_5_9", 1'b0, 32'd5, 32'd9, 33, 32'd0, 32'd5);

        // Restart mid-operation: first result must never surface
        start_op(1'b0, 32'd1000, 32'd3);
        cycles = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (p4_divider_done) cycles++;
        end
        check("restart_early_done", cycles, 0);
        run("restart_50_5", 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0);

        // Reset mid-operation
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_done", {31'd0, p4_divider_done}, 32'd1);
        check("midrst_busy", {31'd0, p4_divider_busy}, 32'd0);
        check("midrst_quo", p4_quotient, 32'd0);
        check("midrst_rem", p4_remainder, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run("post_rst_9_2", 1'b0, 32'd9, 32'd2, 33, 32'd4, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
